// File: rtl/qif_pkg.sv
// Shared types and constants for the time-multiplexed QIF neuron scheduler.
// Holds the scheduler state encoding, datapath widths and default neuron constants.
package qif_pkg;

    localparam int VW = 8;
    localparam int SW = 10;

    localparam logic [VW-1:0] V_PEAK_DEF  = 8'd240;
    localparam logic [VW-1:0] V_RESET_DEF = 8'd0;
    localparam logic [VW-1:0] LEAK_DEF    = 8'd1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CALC,
        S_WB,
        S_EMIT,
        S_DONE
    } state_t;

endpackage

// File: rtl/qif_update.sv
// QIF membrane update: sum = v + (v*v >> 8) + b; spike above V_PEAK, else leak with floor at 0.
// Latency: purely combinational.
// Backpressure: none; the scheduler decides when the result is consumed.
module qif_update
    import qif_pkg::*;
#(
    parameter logic [VW-1:0] V_PEAK  = V_PEAK_DEF,
    parameter logic [VW-1:0] V_RESET = V_RESET_DEF,
    parameter logic [VW-1:0] LEAK    = LEAK_DEF
) (
    input  logic [VW-1:0] v_i,
    input  logic [VW-1:0] b_i,
    output logic [VW-1:0] result_o,
    output logic          spike_o
);

    logic [2*VW-1:0] sq;
    logic [VW-1:0]   sq_hi;
    logic [SW-1:0]   sum;

    assign sq    = v_i * v_i;
    assign sq_hi = VW'(sq >> VW);
    assign sum   = SW'(v_i) + SW'(sq_hi) + SW'(b_i);

    // Without a spike sum <= V_PEAK, so the truncation to VW bits is lossless.
    always_comb begin
        spike_o  = (sum > SW'(V_PEAK));
        result_o = V_RESET;
        if (!spike_o) begin
            result_o = (sum >= SW'(LEAK)) ? VW'(sum - SW'(LEAK)) : '0;
        end
    end

endmodule

// File: rtl/qif_tdm_scheduler.sv
// Sweeps N_NEURONS virtual QIF neurons through one shared update unit per start request.
// Latency: 2 cycles per neuron plus 1 per spike; done pulses in cycle 2*N+1 when spike-free.
// Backpressure: spike events hold in EMIT until spike_ready; QIF_REFRACTORY_EN adds refractory counters.
module qif_tdm_scheduler
    import qif_pkg::*;
#(
    parameter int              N_NEURONS    = 4,
    parameter logic [VW-1:0]   V_PEAK       = V_PEAK_DEF,
    parameter logic [VW-1:0]   V_RESET      = V_RESET_DEF,
    parameter logic [VW-1:0]   LEAK         = LEAK_DEF,
    parameter int              REFRAC_STEPS = 2,
    localparam int             IW           = $clog2(N_NEURONS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    output logic          busy,
    output logic          done,
    input  logic          cfg_we,
    input  logic [IW-1:0] cfg_addr,
    input  logic [VW-1:0] cfg_b,
    output logic          spike_valid,
    output logic [IW-1:0] spike_idx,
    input  logic          spike_ready,
    input  logic [IW-1:0] mon_sel,
    output logic [VW-1:0] mon_v
);

    if (N_NEURONS < 2 || N_NEURONS > 16 || (N_NEURONS & (N_NEURONS - 1)) != 0
        || REFRAC_STEPS < 0) begin : g_param_chk
        $error("qif_tdm_scheduler: unsupported N_NEURONS or REFRAC_STEPS");
    end

    state_t        state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [VW-1:0] v_q [N_NEURONS];
    logic [VW-1:0] b_q [N_NEURONS];
    logic [VW-1:0] res_q;
    logic          spk_q;
    logic [VW-1:0] mon_q;

    logic [VW-1:0] upd_result;
    logic          upd_spike;
    logic          last_idx;
    logic          wb_spike;
    logic [VW-1:0] wb_v;

    qif_update #(
        .V_PEAK  (V_PEAK),
        .V_RESET (V_RESET),
        .LEAK    (LEAK)
    ) u_update (
        .v_i      (v_q[idx_q]),
        .b_i      (b_q[idx_q]),
        .result_o (upd_result),
        .spike_o  (upd_spike)
    );

    assign last_idx = (idx_q == IW'(N_NEURONS - 1));

`ifdef QIF_REFRACTORY_EN
    localparam int RW = (REFRAC_STEPS > 1) ? $clog2(REFRAC_STEPS + 1) : 1;

    logic [RW-1:0] refr_q [N_NEURONS];
    logic          refr_active;

    assign refr_active = (refr_q[idx_q] != '0);
    assign wb_spike    = spk_q && !refr_active;
    assign wb_v        = refr_active ? V_RESET : res_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_NEURONS; i++) refr_q[i] <= '0;
        end else if (state_q == S_WB) begin
            if (refr_active) begin
                refr_q[idx_q] <= refr_q[idx_q] - RW'(1);
            end else if (spk_q) begin
                refr_q[idx_q] <= RW'(REFRAC_STEPS);
            end
        end
    end
`else
    assign wb_spike = spk_q;
    assign wb_v     = res_q;
`endif

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            S_IDLE: begin
                idx_d = '0;
                if (start) state_d = S_CALC;
            end
            S_CALC: state_d = S_WB;
            S_WB: begin
                if (wb_spike) begin
                    state_d = S_EMIT;
                end else if (last_idx) begin
                    state_d = S_DONE;
                end else begin
                    idx_d   = idx_q + IW'(1);
                    state_d = S_CALC;
                end
            end
            S_EMIT: begin
                if (spike_ready) begin
                    if (last_idx) begin
                        state_d = S_DONE;
                    end else begin
                        idx_d   = idx_q + IW'(1);
                        state_d = S_CALC;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            res_q <= V_RESET;
            spk_q <= 1'b0;
        end else if (state_q == S_CALC) begin
            res_q <= upd_result;
            spk_q <= upd_spike;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_NEURONS; i++) v_q[i] <= V_RESET;
        end else if (state_q == S_WB) begin
            v_q[idx_q] <= wb_v;
        end
    end

    // Bias writes are allowed mid-sweep; CALC sees the old value on a same-cycle collision.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_NEURONS; i++) b_q[i] <= '0;
        end else if (cfg_we) begin
            b_q[cfg_addr] <= cfg_b;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) mon_q <= V_RESET;
        else     mon_q <= v_q[mon_sel];
    end

    assign busy        = (state_q != S_IDLE);
    assign done        = (state_q == S_DONE);
    assign spike_valid = (state_q == S_EMIT);
    assign spike_idx   = idx_q;
    assign mon_v       = mon_q;

endmodule
